// File: rtl/ps2_keyboard.sv
// PS/2 scan-code-set-2 receiver: 2-flop sync, FILTER-deep clock filter, F0/E0/E1 prefix resolution; strb 12 cycles after stop fall, no backpressure (strobes are >= 1 frame apart).
// Optional odd-parity qualification when PS2_PARITY_EN is defined; otherwise the parity bit is ignored.
module ps2_keyboard #(
  parameter int FILTER  = 8,
  parameter int TIMEOUT = 56000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2Ck,
  input  logic       ps2D,
  output logic       strb,
  output logic       make,
  output logic [7:0] code,
  output logic       ext,
  output logic       err
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  logic              ck_s1_q, ck_s2_q, d_s1_q, d_s2_q;
  logic [FILTER-1:0] filt_q;
  logic              fck_q, fall_q, bit_q;

  state_t            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [7:0]        sh_q, sh_d;
  logic              brk_q, brk_d, extf_q, extf_d;
  logic              strb_q, strb_d, err_q, err_d;
  logic              make_q, make_d, ext_q, ext_d;
  logic [7:0]        code_q, code_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic              frame_ok, is_resp, drop;

  // Front end: synchronise, filter, and register the fck fall with its data sample.
  always_ff @(posedge clock) begin
    if (reset) begin
      ck_s1_q <= 1'b1;
      ck_s2_q <= 1'b1;
      d_s1_q  <= 1'b1;
      d_s2_q  <= 1'b1;
      filt_q  <= '1;
      fck_q   <= 1'b1;
      fall_q  <= 1'b0;
      bit_q   <= 1'b1;
    end else begin
      ck_s1_q <= ps2Ck;
      ck_s2_q <= ck_s1_q;
      d_s1_q  <= ps2D;
      d_s2_q  <= d_s1_q;
      filt_q  <= {filt_q[FILTER-2:0], ck_s2_q};
      if (&filt_q)       fck_q <= 1'b1;
      else if (~|filt_q) fck_q <= 1'b0;
      fall_q  <= fck_q & ~|filt_q;
      bit_q   <= d_s2_q;
    end
  end

`ifdef PS2_PARITY_EN
  logic par_q, par_d;
  assign frame_ok = bit_q & (^{sh_q, par_q});
`else
  assign frame_ok = bit_q;
`endif

  assign is_resp = (sh_q == 8'hAA) || (sh_q == 8'hFA) || (sh_q == 8'hFE) ||
                   (sh_q == 8'hEE) || (sh_q == 8'h00) || (sh_q == 8'hFF);
  assign drop    = is_resp & ~brk_q & ~extf_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    brk_d   = brk_q;
    extf_d  = extf_q;
    strb_d  = 1'b0;
    err_d   = 1'b0;
    make_d  = make_q;
    code_d  = code_q;
    ext_d   = ext_q;
    tmo_d   = tmo_q;
`ifdef PS2_PARITY_EN
    par_d   = par_q;
`endif
    if (fall_q) begin
      // A bit edge always beats a coincident timeout.
      tmo_d = '0;
      case (state_q)
        S_IDLE: begin
          if (!bit_q) begin
            state_d = S_DATA;
            cnt_d   = 3'd0;
          end else begin
            err_d = 1'b1;
          end
        end
        S_DATA: begin
          sh_d  = {bit_q, sh_q[7:1]};
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd7) state_d = S_PARITY;
        end
        S_PARITY: begin
`ifdef PS2_PARITY_EN
          par_d = bit_q;
`endif
          state_d = S_STOP;
        end
        S_STOP: begin
          state_d = S_IDLE;
          if (!frame_ok) begin
            err_d = 1'b1;
          end else if (sh_q == 8'hF0) begin
            brk_d = 1'b1;
          end else if ((sh_q == 8'hE0) || (sh_q == 8'hE1)) begin
            extf_d = 1'b1;
          end else if (!drop) begin
            strb_d = 1'b1;
            code_d = sh_q;
            make_d = ~brk_q;
            ext_d  = extf_q;
            brk_d  = 1'b0;
            extf_d = 1'b0;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end else if (state_q != S_IDLE) begin
      if (tmo_q == TMO_LAST) begin
        state_d = S_IDLE;
        err_d   = 1'b1;
        tmo_d   = '0;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end else begin
      tmo_d = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 3'd0;
      sh_q    <= 8'h00;
      brk_q   <= 1'b0;
      extf_q  <= 1'b0;
      strb_q  <= 1'b0;
      err_q   <= 1'b0;
      make_q  <= 1'b0;
      code_q  <= 8'h00;
      ext_q   <= 1'b0;
      tmo_q   <= '0;
`ifdef PS2_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      brk_q   <= brk_d;
      extf_q  <= extf_d;
      strb_q  <= strb_d;
      err_q   <= err_d;
      make_q  <= make_d;
      code_q  <= code_d;
      ext_q   <= ext_d;
      tmo_q   <= tmo_d;
`ifdef PS2_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign strb = strb_q;
  assign err  = err_q;
  assign make = make_q;
  assign code = code_q;
  assign ext  = ext_q;

endmodule

// File: tb/tb_ps2_keyboard.sv
// Directed bench for ps2_keyboard: frames are bit-banged on the raw PS/2 lines, strobes/errors tallied on the falling clock edge.
module tb_ps2_keyboard;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ps2Ck = 1'b1;
  logic       ps2D = 1'b1;
  logic       strb, make, ext, err;
  logic [7:0] code;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int fall_cyc = 0;
  int strb_cnt = 0;
  int err_cnt = 0;
  int strb_cyc = 0;
  int err_cyc = 0;
  int s0, e0;

  ps2_keyboard dut (
    .clock(clk),
    .reset(reset),
    .ps2Ck(ps2Ck),
    .ps2D (ps2D),
    .strb (strb),
    .make (make),
    .code (code),
    .ext  (ext),
    .err  (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (strb) begin
      strb_cnt = strb_cnt + 1;
      strb_cyc = cyc;
    end
    if (err) begin
      err_cnt = err_cnt + 1;
      err_cyc = cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      failures = failures + 1;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ps2_bit(input logic v);
    ps2D = v;
    tick(8);
    ps2Ck = 1'b0;
    fall_cyc = cyc;
    tick(20);
    ps2Ck = 1'b1;
    tick(12);
  endtask

  // nd < 8 sends a truncated frame: start bit plus nd data bits only.
  task automatic send(input logic [7:0] b, input logic flip, input int nd);
    ps2_bit(1'b0);
    for (int i = 0; i < nd; i++) ps2_bit(b[i]);
    if (nd == 8) begin
      ps2_bit((~^b) ^ flip);
      ps2_bit(1'b1);
    end
  endtask

  initial begin
    tick(4);
    check("rst_strb", {31'd0, strb}, 32'd0);
    check("rst_err",  {31'd0, err},  32'd0);
    check("rst_make", {31'd0, make}, 32'd0);
    check("rst_ext",  {31'd0, ext},  32'd0);
    check("rst_code", {24'd0, code}, 32'h00);
    reset = 1'b0;
    tick(20);

    // Plain make of A key
    send(8'h1C, 1'b0, 8);
    tick(20);
    check("make_cnt",     strb_cnt, 1);
    check("make_latency", strb_cyc - fall_cyc, 12);
    check("make_code",    {24'd0, code}, 32'h1C);
    check("make_make",    {31'd0, make}, 32'd1);
    check("make_ext",     {31'd0, ext},  32'd0);
    check("make_noerr",   err_cnt, 0);

    // Extended break: E0 F0 75
    send(8'hE0, 1'b0, 8);
    send(8'hF0, 1'b0, 8);
    check("pfx_nostrb", strb_cnt, 1);
    send(8'h75, 1'b0, 8);
    tick(20);
    check("brk_cnt",  strb_cnt, 2);
    check("brk_code", {24'd0, code}, 32'h75);
    check("brk_make", {31'd0, make}, 32'd0);
    check("brk_ext",  {31'd0, ext},  32'd1);
    check("hold_code", {24'd0, code}, 32'h75);
    send(8'h1C, 1'b0, 8);
    tick(20);
    check("post_cnt",  strb_cnt, 3);
    check("post_make", {31'd0, make}, 32'd1);
    check("post_ext",  {31'd0, ext},  32'd0);
    check("post_err",  err_cnt, 0);

    // Parity flipped
    send(8'h1C, 1'b1, 8);
    tick(20);
`ifdef PS2_PARITY_EN
    check("par_strb", strb_cnt, 3);
    check("par_err",  err_cnt, 1);
`else
    check("par_strb", strb_cnt, 4);
    check("par_code", {24'd0, code}, 32'h1C);
    check("par_err",  err_cnt, 0);
`endif

    // Truncated frame, then timeout
    s0 = strb_cnt;
    e0 = err_cnt;
    send(8'h5A, 1'b0, 4);
    tick(55000);
    check("tmo_early", err_cnt, e0);
    tick(1500);
    check("tmo_err",    err_cnt, e0 + 1);
    check("tmo_window", {31'd0, (err_cyc >= fall_cyc + 56000) && (err_cyc <= fall_cyc + 56020)}, 32'd1);
    send(8'h29, 1'b0, 8);
    tick(20);
    check("tmo_next_cnt",  strb_cnt, s0 + 1);
    check("tmo_next_code", {24'd0, code}, 32'h29);
    check("tmo_next_err",  err_cnt, e0 + 1);

    // Short glitches on the clock while idle
    s0 = strb_cnt;
    e0 = err_cnt;
    for (int g = 0; g < 3; g++) begin
      ps2Ck = 1'b0;
      tick(5);
      ps2Ck = 1'b1;
      tick(30);
    end
    check("glitch_err",  err_cnt, e0);
    check("glitch_strb", strb_cnt, s0);

    // Controller response with no prefix pending
    send(8'hAA, 1'b0, 8);
    tick(20);
    check("aa_strb", strb_cnt, s0);
    check("aa_err",  err_cnt, e0);

    // Reset in the middle of a frame
    send(8'h1C, 1'b0, 3);
    reset = 1'b1;
    tick(1);
    check("mid_rst_strb", {31'd0, strb}, 32'd0);
    check("mid_rst_make", {31'd0, make}, 32'd0);
    check("mid_rst_code", {24'd0, code}, 32'h00);
    check("mid_rst_ext",  {31'd0, ext},  32'd0);
    check("mid_rst_err",  {31'd0, err},  32'd0);
    reset = 1'b0;
    tick(100);
    check("mid_rst_noerr", err_cnt, e0);
    send(8'h1C, 1'b0, 8);
    tick(20);
    check("after_rst_cnt",  strb_cnt, s0 + 1);
    check("after_rst_code", {24'd0, code}, 32'h1C);
    check("after_rst_make", {31'd0, make}, 32'd1);
    check("after_rst_ext",  {31'd0, ext},  32'd0);
    check("after_rst_err",  err_cnt, e0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
